mem_initiator: RTL and testbench
================================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width of the memory bus.
REQ-002 Parameter DATA_W, default 32, data width of the memory bus.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  burst request present.
REQ-006 req_ready  output  1  initiator idle, request accepted on req_valid&&req_ready.
REQ-007 req_write  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  ADDR_W  start word address.
REQ-009 req_len  input  ADDR_W  burst length minus one (0..63 -> 1..64 words).
REQ-010 wdata_valid / wdata_ready  input / output  1 / 1  write-data stream handshake.
REQ-011 wdata  input  DATA_W  write word.
REQ-012 rdata_valid / rdata_ready  output / input  1 / 1  read-data stream handshake.
REQ-013 rdata  output  DATA_W  read word; rdata_last  output  1  marks final word of burst.
REQ-014 done  output  1  one-cycle pulse when a burst fully completes.
REQ-015 cs, rw_  output  1 / 1  memory chip select; rw_ = 1 read, 0 write.
REQ-016 adder  output  ADDR_W  memory word address.
REQ-017 mem_datain  output  DATA_W  write data to memory; mem_dataout  input  DATA_W  combinational read data from memory.

Function
REQ-018 States: IDLE, WR, RD, DRAIN; req_ready = (state==IDLE).
REQ-019 Accept: IDLE -> WR if req_write else RD; latch addr register = req_addr, remaining counter = req_len.
REQ-020 WR: wdata_ready = 1; cs=1, rw_=0, adder=addr, mem_datain=wdata combinationally only while wdata_valid; memory write occurs on that edge.
REQ-021 WR handshake: addr increments mod 2^ADDR_W (63 -> 0 wraps); remaining decrements; on handshake with remaining==0 -> IDLE, done=1 next cycle.
REQ-022 RD: bus read issued (cs=1, rw_=1, adder=addr) when !rdata_valid || rdata_ready; mem_dataout captured into rdata on that edge, rdata_valid=1 next cycle.
REQ-023 Simultaneous rdata consume and new bus read in same cycle allowed: full one-word-per-cycle throughput; zero bubbles when rdata_ready held high.
REQ-024 rdata/rdata_valid/rdata_last held stable while rdata_valid && !rdata_ready; no bus read issued then.
REQ-025 Read latency: first rdata_valid two cycles after request acceptance edge.
REQ-026 Last bus read (remaining==0) -> DRAIN with rdata_last=1 on captured word; DRAIN -> IDLE on rdata handshake, done=1 next cycle.
REQ-027 Bus idle value outside active cycles: cs=0, rw_=1, adder=0, mem_datain=0; cs never asserted in IDLE or DRAIN.
REQ-028 req_valid ignored when req_ready=0; wdata_valid ignored outside WR.
REQ-029 Address wrap is silent; a 64-word burst touches every address exactly once.

Reset
REQ-030 reset low asynchronously forces: state IDLE, req_ready=1, cs=0, rw_=1, adder=0, mem_datain=0, wdata_ready=0, rdata_valid=0, rdata=0, rdata_last=0, done=0, counters 0.
REQ-031 Reset mid-burst abandons the burst: no done pulse, no further bus cycles, remaining words discarded.
REQ-032 Deassertion is synchronised externally; first request acceptable on the first rising edge after release.

Structure
REQ-033 Shared package mem_pkg holds ADDR_W, DATA_W defaults and state encoding (IDLE=0, WR=1, RD=2, DRAIN=3).
REQ-034 Single module; no sub-module; the read output register is an in-module one-entry buffer.

Verification
REQ-035 Write burst addr=5, len=3, data 0xA0..0xA3 streamed back-to-back -> memory words 5..8 = 0xA0..0xA3, four cs/rw_=0 cycles, done one cycle after last.
REQ-036 Read burst addr=5, len=3, rdata_ready=1 -> rdata 0xA0..0xA3 on four consecutive cycles, rdata_last on the 4th, first valid two cycles after acceptance.
REQ-037 Wrap: write addr=62, len=3 data 1..4 -> mem[62]=1, mem[63]=2, mem[0]=3, mem[1]=4.
REQ-038 Backpressure: read len=2 with rdata_ready low 3 cycles after first valid -> rdata held, cs=0 during stall, no word lost or duplicated.
REQ-039 Reset asserted after 2 of 4 write words -> cs=0 immediately, req_ready=1, no done; following read of same addresses returns only 2 new words.
REQ-040 req_valid asserted during active burst -> req_ready=0, request not taken until IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory initiator: bus width defaults and
// the controller state encoding.
package mem_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR    = 2'd1,
      RD    = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/mem_initiator.sv
// Burst initiator that bridges a request/stream interface to a single-port
// synchronous-write, combinational-read word memory.
module mem_initiator
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_last,
   output logic              done,
   output logic              cs,
   output logic              rw_,
   output logic [ADDR_W-1:0] adder,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] remaining_q;
   logic              last_beat;
   logic              accept;
   logic              wr_beat;
   logic              rd_issue;
   logic              rd_pop;

   assign last_beat = (remaining_q == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_nxt   = state;
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      accept      = 1'b0;
      wr_beat     = 1'b0;
      rd_issue    = 1'b0;
      rd_pop      = rdata_valid && rdata_ready;
      cs          = 1'b0;
      rw_         = 1'b1;
      adder       = '0;
      mem_datain  = '0;

      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = req_write ? WR : RD;
            end
         end
         WR: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               wr_beat    = 1'b1;
               cs         = 1'b1;
               rw_        = 1'b0;
               adder      = addr_q;
               mem_datain = wdata;
               if (last_beat) state_nxt = IDLE;
            end
         end
         RD: begin
            // A read may be issued whenever the output buffer is empty or being emptied.
            if (!rdata_valid || rdata_ready) begin
               rd_issue = 1'b1;
               cs       = 1'b1;
               adder    = addr_q;
               if (last_beat) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (rd_pop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q      <= '0;
         remaining_q <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         done        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         done <= (wr_beat && last_beat) || ((state == DRAIN) && rd_pop);

         if (accept) begin
            addr_q      <= req_addr;
            remaining_q <= req_len;
         end else if (wr_beat || rd_issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (!last_beat) remaining_q <= remaining_q - ADDR_W'(1);
         end

         // Capture wins over pop so a consume and a new read in one cycle keep the buffer full.
         if (rd_issue) begin
            rdata       <= mem_dataout;
            rdata_valid <= 1'b1;
            rdata_last  <= last_beat;
         end else if (rd_pop) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: a bench-side memory, a reference memory
// image, and expectation queues popped by a free-running monitor.
`timescale 1ns/1ps
module tb_mem_initiator;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [AW-1:0] req_len = '0;
   logic          wdata_valid = 1'b0;
   logic          wdata_ready;
   logic [DW-1:0] wdata = '0;
   logic          rdata_valid;
   logic          rdata_ready = 1'b0;
   logic [DW-1:0] rdata;
   logic          rdata_last;
   logic          done;
   logic          cs;
   logic          rw_;
   logic [AW-1:0] adder;
   logic [DW-1:0] mem_datain;
   logic [DW-1:0] mem_dataout;

   always #5 clk = ~clk;

   mem_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .wdata      (wdata),
      .rdata_valid(rdata_valid),
      .rdata_ready(rdata_ready),
      .rdata      (rdata),
      .rdata_last (rdata_last),
      .done       (done),
      .cs         (cs),
      .rw_        (rw_),
      .adder      (adder),
      .mem_datain (mem_datain),
      .mem_dataout(mem_dataout)
   );

   // Environment memory driven by the DUT bus.
   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   assign mem_dataout = mem[adder];
   always @(posedge clk) if (cs && !rw_) mem[adder] <= mem_datain;

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_exp_t;
   typedef struct { logic [DW-1:0] d; logic last; } rd_exp_t;
   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int exp_done = 0;
   int n_done = 0;
   int n_wr_cyc = 0;
   int n_rd_iss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name, input string detail);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s at %0t", name, detail, $time);
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_rdata = '0;
   logic          prev_last = 1'b0;
   logic          done_due = 1'b0;
   wr_exp_t       we;
   rd_exp_t       re;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
         done_due   = 1'b0;
      end else begin
         if (done) n_done++;
         if (done_due) begin
            check("rd_done_timing", 64'(done), 64'(1));
            done_due = 1'b0;
         end
         if (prev_stall) begin
            check("hold_valid", 64'(rdata_valid), 64'(1));
            check("hold_rdata", 64'(rdata), 64'(prev_rdata));
            check("hold_last", 64'(rdata_last), 64'(prev_last));
         end
         if (!cs) check("bus_idle", 64'({rw_, adder, mem_datain}), 64'({1'b1, {AW{1'b0}}, {DW{1'b0}}}));
         if (req_ready) check("idle_cs", 64'(cs), 64'(0));
         if (cs && !rw_) begin
            n_wr_cyc++;
            if (wr_q.size() == 0) fail_now("wr_unexpected", $sformatf("got write to 0x%0h, required none", adder));
            else begin
               we = wr_q.pop_front();
               check("wr_addr", 64'(adder), 64'(we.a));
               check("wr_data", 64'(mem_datain), 64'(we.d));
            end
         end
         if (cs && rw_) n_rd_iss++;
         if (rdata_valid && rdata_ready) begin
            if (rd_q.size() == 0) fail_now("rd_unexpected", $sformatf("got word 0x%0h, required none", rdata));
            else begin
               re = rd_q.pop_front();
               check("rd_data", 64'(rdata), 64'(re.d));
               check("rd_last", 64'(rdata_last), 64'(re.last));
            end
            if (rdata_last) done_due = 1'b1;
         end
         prev_stall = rdata_valid && !rdata_ready;
         prev_rdata = rdata;
         prev_last  = rdata_last;
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (!req_ready) fail_now("req_ready_timeout", "got req_ready 0, required 1");
   endtask

   task automatic write_burst(input int a, input int l, input logic [DW-1:0] base,
                              input bit rnd_data, input bit gaps);
      logic [DW-1:0] d;
      int            c0;
      wait_ready();
      exp_done++;
      c0        = n_wr_cyc;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = AW'(a);
      req_len   = AW'(l);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i <= l; i++) begin
         if (gaps) begin
            wdata_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         d = rnd_data ? DW'($urandom) : base + DW'(i);
         wr_q.push_back('{a: AW'((a + i) % DEPTH), d: d});
         ref_mem[(a + i) % DEPTH] = d;
         wdata_valid = 1'b1;
         wdata       = d;
         @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      check("wr_done", 64'(done), 64'(1));
      check("wr_cycles", 64'(n_wr_cyc - c0), 64'(l + 1));
   endtask

   // mode 0: rdata_ready held high; 1: random ready; 2: ready low for 3 cycles after first valid.
   task automatic read_burst(input int a, input int l, input int mode, input bit hold_req);
      int iss0;
      int k;
      for (int i = 0; i <= l; i++) rd_q.push_back('{d: ref_mem[(a + i) % DEPTH], last: (i == l)});
      wait_ready();
      exp_done++;
      iss0        = n_rd_iss;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_addr    = AW'(a);
      req_len     = AW'(l);
      rdata_ready = (mode == 0);
      @(posedge clk); #1;
      if (hold_req) begin
         req_write = 1'b1;
         req_addr  = AW'(40);
         req_len   = '0;
      end else req_valid = 1'b0;
      check("rd_lat_early", 64'(rdata_valid), 64'(0));
      @(posedge clk); #1;
      check("rd_lat_first", 64'(rdata_valid), 64'(1));
      if (mode == 0) begin
         for (int i = 0; i <= l; i++) begin
            check("rd_stream", 64'(rdata_valid), 64'(1));
            if (hold_req) check("busy_ready", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
         end
         check("rd_done", 64'(done), 64'(1));
      end else begin
         if (mode == 2) begin
            repeat (3) begin
               @(posedge clk); #1;
               check("stall_cs", 64'(cs), 64'(0));
            end
         end
         k = 0;
         while (!done && k < 400) begin
            rdata_ready = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (hold_req) check("busy_ready", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            k++;
         end
         if (!done) fail_now("rd_timeout", "got done 0, required 1");
      end
      check("rd_issues", 64'(n_rd_iss - iss0), 64'(l + 1));
   endtask

   initial begin
      logic [DW-1:0] d;
      int            a;
      int            l;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'hC0DE_0000 + DW'(i);
         ref_mem[i] = 32'hC0DE_0000 + DW'(i);
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'(1));
      check("rst_cs", 64'(cs), 64'(0));
      check("rst_rw", 64'(rw_), 64'(1));
      check("rst_adder", 64'(adder), 64'(0));
      check("rst_mem_datain", 64'(mem_datain), 64'(0));
      check("rst_wdata_ready", 64'(wdata_ready), 64'(0));
      check("rst_rdata_valid", 64'(rdata_valid), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      check("rst_rdata_last", 64'(rdata_last), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      reset = 1'b1;

      // Directed write/read at addr 5.
      write_burst(5, 3, 32'hA0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) check("mem_5_8", 64'(mem[5 + i]), 64'(32'hA0 + i));
      read_burst(5, 3, 0, 1'b0);

      // Address wrap.
      write_burst(62, 3, 32'd1, 1'b0, 1'b0);
      check("wrap_62", 64'(mem[62]), 64'(1));
      check("wrap_63", 64'(mem[63]), 64'(2));
      check("wrap_0", 64'(mem[0]), 64'(3));
      check("wrap_1", 64'(mem[1]), 64'(4));
      read_burst(62, 3, 0, 1'b0);

      // Backpressure.
      read_burst(10, 2, 2, 1'b0);

      // Reset after two of four write words.
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = AW'(20);
      req_len   = AW'(3);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         d = 32'h5500 + DW'(i);
         wr_q.push_back('{a: AW'(20 + i), d: d});
         ref_mem[20 + i] = d;
         wdata_valid = 1'b1;
         wdata       = d;
         @(posedge clk); #1;
      end
      wdata = 32'h55FF;
      #2 reset = 1'b0;
      #1;
      check("mid_rst_cs", 64'(cs), 64'(0));
      check("mid_rst_req_ready", 64'(req_ready), 64'(1));
      check("mid_rst_done", 64'(done), 64'(0));
      check("mid_rst_wdata_ready", 64'(wdata_ready), 64'(0));
      wdata_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_done_after", 64'(done), 64'(0));
      reset = 1'b1;
      read_burst(20, 3, 0, 1'b0);

      // Request held during an active burst; stray write data in IDLE is ignored.
      read_burst(5, 3, 0, 1'b1);
      d = DW'($urandom);
      wr_q.push_back('{a: AW'(40), d: d});
      ref_mem[40] = d;
      exp_done++;
      wdata_valid = 1'b1;
      wdata       = d;
      check("req_ready_back", 64'(req_ready), 64'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("post_accept_busy", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      wdata_valid = 1'b0;
      check("held_req_done", 64'(done), 64'(1));

      // Full 64-word bursts touching every address once.
      write_burst(17, 63, '0, 1'b1, 1'b1);
      read_burst(17, 63, 1, 1'b0);

      // Randomised traffic.
      repeat (40) begin
         a = $urandom_range(0, DEPTH - 1);
         l = ($urandom_range(0, 3) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) write_burst(a, l, '0, 1'b1, 1'($urandom_range(0, 1)));
         else                            read_burst(a, l, $urandom_range(0, 1), 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("wr_q_empty", 64'(wr_q.size()), 64'(0));
      check("rd_q_empty", 64'(rd_q.size()), 64'(0));
      check("done_count", 64'(n_done), 64'(exp_done));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion, required $finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
